custom_stage_ctrl: RTL and testbench

CUSTOM_STAGE_CTRL -- requirements
Module: custom_stage_ctrl

---
 rtl/custom_stage_ctrl.sv | 111 +++++++++++
 tb/tb_custom_stage_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/custom_stage_ctrl.sv
// Stage sequencer: walks cnt_o over NUM_STAGES buffer reads, flags returning data, pulses done_o per run.
// Optional macro CUSTOM_STAGE_STALL_CNT_EN adds stall_cnt_o (read cycles stalled by the memory, saturating).
module custom_stage_ctrl #(
  parameter int NUM_STAGES = 25,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mem_rdy_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             rd_en_o,
  output logic             data_vld_o,
  output logic             last_o,
  output logic             busy_o,
`ifdef CUSTOM_STAGE_STALL_CNT_EN
  output logic [7:0]       stall_cnt_o,
`endif
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STAGES - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             vld_q, vld_nxt;
  logic             last_q, last_nxt;
  logic             accept;

  assign accept = (state_q == RUN) && mem_rdy_i;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    vld_nxt   = accept && !abort_i;
    last_nxt  = accept && !abort_i && (cnt_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        if (accept) begin
          // Final stage holds the counter so it never passes LAST_IDX.
          if (cnt_q == LAST_IDX) state_nxt = DRAIN;
          else                   cnt_nxt   = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Abort overrides start and read acceptance.
    if (abort_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      vld_q   <= vld_nxt;
      last_q  <= last_nxt;
    end
  end

  assign cnt_o      = cnt_q;
  assign rd_en_o    = (state_q == RUN);
  assign data_vld_o = vld_q;
  assign last_o     = last_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

`ifdef CUSTOM_STAGE_STALL_CNT_EN
  logic [7:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 8'd0;
    end else if (state_q == IDLE && state_nxt == RUN) begin
      stall_q <= 8'd0;
    end else if (state_q == RUN && !mem_rdy_i && stall_q != 8'hFF) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_custom_stage_ctrl.sv
// Directed bench for custom_stage_ctrl: full run, stall, abort, held start, async reset, start+abort.
module tb_custom_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       mem_rdy_i = 1'b1;
  logic [4:0] cnt_o;
  logic       rd_en_o, data_vld_o, last_o, busy_o, done_o;
`ifdef CUSTOM_STAGE_STALL_CNT_EN
  logic [7:0] stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  custom_stage_ctrl #(.NUM_STAGES(25), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .mem_rdy_i  (mem_rdy_i),
    .cnt_o      (cnt_o),
    .rd_en_o    (rd_en_o),
    .data_vld_o (data_vld_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
`ifdef CUSTOM_STAGE_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt"},   32'(cnt_o), 32'd0);
    chk({tag, "_rden"},  32'(rd_en_o), 32'd0);
    chk({tag, "_vld"},   32'(data_vld_o), 32'd0);
    chk({tag, "_last"},  32'(last_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
  endtask

  initial begin
    int vld_cnt, last_at, done_at, exp_cnt, done_cnt;

    // Reset state
    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("idle");

    // Full run, memory always ready
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    vld_cnt = 0; last_at = -1; done_at = -1;
    for (int i = 0; i < 28; i++) begin
      if (i <= 24) begin
        chk("run_cnt", 32'(cnt_o), 32'(i));
        chk("run_rden", 32'(rd_en_o), 32'd1);
      end
      if (data_vld_o) vld_cnt++;
      if (last_o && last_at < 0) last_at = i;
      if (done_o && done_at < 0) done_at = i;
      if (i == 27) chk("run_busy_after", 32'(busy_o), 32'd0);
      if (i < 27) step();
    end
    chk("run_beats", 32'(vld_cnt), 32'd25);
    chk("run_last_at", 32'(last_at), 32'd25);
    chk("run_done_at", 32'(done_at), 32'd26);

    // Three stall cycles at stage 7
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    vld_cnt = 0; done_at = -1;
    for (int i = 0; i < 31; i++) begin
      mem_rdy_i = !(i >= 7 && i <= 9);
      exp_cnt = (i <= 7) ? i : (i <= 10) ? 7 : ((i - 3) > 24 ? 24 : i - 3);
      if (i <= 29) chk("stall_cnt", 32'(cnt_o), 32'(exp_cnt));
      if (i >= 8 && i <= 10) chk("stall_gap_vld", 32'(data_vld_o), 32'd0);
      if (data_vld_o) vld_cnt++;
      if (done_o && done_at < 0) begin
        done_at = i;
`ifdef CUSTOM_STAGE_STALL_CNT_EN
        chk("stall_count", 32'(stall_cnt_o), 32'd3);
`endif
      end
      step();
    end
    mem_rdy_i = 1'b1;
    chk("stall_beats", 32'(vld_cnt), 32'd25);
    chk("stall_done_at", 32'(done_at), 32'd29);

    // Abort at stage 12
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("abort_pre_cnt", 32'(cnt_o), 32'd12);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_cnt", 32'(cnt_o), 32'd0);
    chk("abort_vld", 32'(data_vld_o), 32'd0);
    chk("abort_last", 32'(last_o), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_o || busy_o) done_cnt++;
      step();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // start_i held high across a whole run
    start_i = 1'b1;
    step();
    vld_cnt = 0; done_at = -1;
    for (int i = 0; i < 28; i++) begin
      if (data_vld_o) vld_cnt++;
      if (done_o && done_at < 0) done_at = i;
      if (i == 27) chk("hold_idle_gap", 32'(busy_o), 32'd0);
      step();
    end
    chk("hold_beats", 32'(vld_cnt), 32'd25);
    chk("hold_done_at", 32'(done_at), 32'd26);
    chk("hold_restart_busy", 32'(busy_o), 32'd1);
    chk("hold_restart_cnt", 32'(cnt_o), 32'd0);
    start_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;

    // Async reset at stage 20, between clock edges
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("arst_pre_cnt", 32'(cnt_o), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    step();
    #2;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_o || busy_o) done_cnt++;
    end
    chk("arst_stays_idle", 32'(done_cnt), 32'd0);

    // start and abort together in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    chk("sa_busy", 32'(busy_o), 32'd0);
    chk("sa_cnt", 32'(cnt_o), 32'd0);
    start_i = 1'b0;
    abort_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
